// File: rtl/fpu_div_if.sv
// Request/response bundle for the iterative double-precision divider.
// The requester drives the operands and enable; the divider returns the result and flags.
interface fpu_div_if;
   logic        enable;
   logic [1:0]  rmode;
   logic [63:0] opa;
   logic [63:0] opb;
   logic        busy;
   logic        ready;
   logic [63:0] outfp;
   logic        inexact;
   logic        overflow;
   logic        underflow;
   logic        div_by_zero;
   logic        invalid;

   modport master (
      output enable, rmode, opa, opb,
      input  busy, ready, outfp, inexact, overflow, underflow, div_by_zero, invalid
   );

   modport slave (
      input  enable, rmode, opa, opb,
      output busy, ready, outfp, inexact, overflow, underflow, div_by_zero, invalid
   );
endinterface

// File: rtl/fpu_div.sv
// Iterative IEEE-754 double divider: unpack, restoring division one bit per cycle, round.
// Special cases run the full iteration count so every operation takes the same 58 cycles.
module fpu_div #(
   parameter int QBITS = 55,
   parameter int CNT_W = 6
) (
   input  logic     clk,
   input  logic     rst,
   input  logic     srst,
   fpu_div_if.slave bus
);

   typedef enum logic [1:0] {
      IDLE   = 2'd0,
      UNPACK = 2'd1,
      DIVIDE = 2'd2,
      ROUND  = 2'd3
   } state_t;

   typedef enum logic [2:0] {
      SP_NONE = 3'd0,
      SP_NAN  = 3'd1,
      SP_INF  = 3'd2,
      SP_DBZ  = 3'd3,
      SP_ZERO = 3'd4
   } special_t;

   localparam logic [CNT_W-1:0] LAST_CNT = CNT_W'(QBITS - 1);

   state_t             state_r, state_s;
   logic [63:0]        opa_r, opb_r;
   logic [1:0]         rmode_r;
   logic               sign_r;
   logic signed [12:0] exp_r;
   logic [52:0]        mb_r;
   logic [53:0]        rem_r;
   logic [QBITS-1:0]   q_r;
   logic [CNT_W-1:0]   cnt_r;
   special_t           spc_r;

   logic               busy_r, ready_r;
   logic [63:0]        outfp_r;
   logic               inexact_r, overflow_r, underflow_r, dbz_r, invalid_r;

   logic               zero_a_s, zero_b_s, inf_a_s, inf_b_s, nan_a_s, nan_b_s;
   logic [52:0]        ma_s, mb_s;
   special_t           spc_s;

   logic               ge_s;
   logic [53:0]        rem_sel_s, rem_nx_s;

   logic [51:0]        frac_raw_s;
   logic [52:0]        frac_inc_s;
   logic               guard_s, sticky_s, inc_s, carry_s;
   logic signed [12:0] e_s, e_fin_s;
   logic [63:0]        res_s;
   logic               inexact_s, overflow_s, underflow_s, dbz_s, invalid_s;

   // State register
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         state_r <= IDLE;
      end else if (srst) begin
         state_r <= IDLE;
      end else begin
         state_r <= state_s;
      end
   end

   // Next-state sequencing
   always_comb begin
      state_s = state_r;
      case (state_r)
         IDLE: begin
            if (bus.enable) state_s = UNPACK;
            else            state_s = IDLE;
         end
         UNPACK: state_s = DIVIDE;
         DIVIDE: begin
            if (cnt_r == LAST_CNT) state_s = ROUND;
            else                   state_s = DIVIDE;
         end
         ROUND:   state_s = IDLE;
         default: state_s = IDLE;
      endcase
   end

   // Operand classification; denormals collapse to zero
   always_comb begin
      zero_a_s = (opa_r[62:52] == 11'd0);
      zero_b_s = (opb_r[62:52] == 11'd0);
      inf_a_s  = (opa_r[62:52] == 11'h7FF) && (opa_r[51:0] == 52'd0);
      inf_b_s  = (opb_r[62:52] == 11'h7FF) && (opb_r[51:0] == 52'd0);
      nan_a_s  = (opa_r[62:52] == 11'h7FF) && (opa_r[51:0] != 52'd0);
      nan_b_s  = (opb_r[62:52] == 11'h7FF) && (opb_r[51:0] != 52'd0);
      if (zero_a_s) ma_s = 53'd0;
      else          ma_s = {1'b1, opa_r[51:0]};
      if (zero_b_s) mb_s = 53'd0;
      else          mb_s = {1'b1, opb_r[51:0]};
      if (nan_a_s || nan_b_s || (zero_a_s && zero_b_s) || (inf_a_s && inf_b_s)) spc_s = SP_NAN;
      else if (inf_a_s)                                                        spc_s = SP_INF;
      else if (zero_b_s)                                                       spc_s = SP_DBZ;
      else if (zero_a_s || inf_b_s)                                            spc_s = SP_ZERO;
      else                                                                     spc_s = SP_NONE;
   end

   // One restoring-division step; rem stays below 2*mb so 54 bits suffice
   always_comb begin
      ge_s = (rem_r >= {1'b0, mb_r});
      if (ge_s) rem_sel_s = rem_r - {1'b0, mb_r};
      else      rem_sel_s = rem_r;
      rem_nx_s = rem_sel_s << 1'b1;
   end

   // Normalise, round and resolve special/overflow/underflow results
   always_comb begin
      if (q_r[QBITS-1]) begin
         frac_raw_s = q_r[QBITS-2:2];
         guard_s    = q_r[1];
         sticky_s   = q_r[0] | (rem_r != 54'd0);
         e_s        = exp_r;
      end else begin
         frac_raw_s = q_r[QBITS-3:1];
         guard_s    = q_r[0];
         sticky_s   = (rem_r != 54'd0);
         e_s        = exp_r - 13'sd1;
      end
      case (rmode_r)
         2'b00:   inc_s = guard_s & (sticky_s | frac_raw_s[0]);
         2'b01:   inc_s = 1'b0;
         2'b10:   inc_s = ~sign_r & (guard_s | sticky_s);
         2'b11:   inc_s = sign_r & (guard_s | sticky_s);
         default: inc_s = 1'b0;
      endcase
      // The hidden bit is always 1, so a fraction carry is the significand carry
      frac_inc_s = {1'b0, frac_raw_s} + {52'd0, inc_s};
      carry_s    = frac_inc_s[52];
      if (carry_s) e_fin_s = e_s + 13'sd1;
      else         e_fin_s = e_s;

      res_s       = 64'd0;
      inexact_s   = 1'b0;
      overflow_s  = 1'b0;
      underflow_s = 1'b0;
      dbz_s       = 1'b0;
      invalid_s   = 1'b0;
      case (spc_r)
         SP_NAN: begin
            res_s     = 64'h7FF8_0000_0000_0000;
            invalid_s = 1'b1;
         end
         SP_INF: res_s = {sign_r, 11'h7FF, 52'd0};
         SP_DBZ: begin
            res_s = {sign_r, 11'h7FF, 52'd0};
            dbz_s = 1'b1;
         end
         SP_ZERO: res_s = {sign_r, 63'd0};
         SP_NONE: begin
            if (e_fin_s >= 13'sd2047) begin
               overflow_s = 1'b1;
               inexact_s  = 1'b1;
               if ((rmode_r == 2'b01) || ((rmode_r == 2'b10) && sign_r) ||
                   ((rmode_r == 2'b11) && !sign_r)) begin
                  res_s = {sign_r, 63'h7FEF_FFFF_FFFF_FFFF};
               end else begin
                  res_s = {sign_r, 11'h7FF, 52'd0};
               end
            end else if (e_fin_s <= 13'sd0) begin
               res_s       = {sign_r, 63'd0};
               underflow_s = 1'b1;
               inexact_s   = 1'b1;
            end else begin
               res_s     = {sign_r, e_fin_s[10:0], frac_inc_s[51:0]};
               inexact_s = guard_s | sticky_s;
            end
         end
         default: res_s = 64'd0;
      endcase
   end

   // Operand capture, iteration registers and registered results
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         opa_r <= 64'd0;  opb_r <= 64'd0;  rmode_r <= 2'd0;
         sign_r <= 1'b0;  exp_r <= 13'sd0; mb_r <= 53'd0;
         rem_r <= 54'd0;  q_r <= {QBITS{1'b0}}; cnt_r <= {CNT_W{1'b0}};
         spc_r <= SP_NONE;
         busy_r <= 1'b0;  ready_r <= 1'b0; outfp_r <= 64'd0;
         inexact_r <= 1'b0; overflow_r <= 1'b0; underflow_r <= 1'b0;
         dbz_r <= 1'b0;   invalid_r <= 1'b0;
      end else if (srst) begin
         opa_r <= 64'd0;  opb_r <= 64'd0;  rmode_r <= 2'd0;
         sign_r <= 1'b0;  exp_r <= 13'sd0; mb_r <= 53'd0;
         rem_r <= 54'd0;  q_r <= {QBITS{1'b0}}; cnt_r <= {CNT_W{1'b0}};
         spc_r <= SP_NONE;
         busy_r <= 1'b0;  ready_r <= 1'b0; outfp_r <= 64'd0;
         inexact_r <= 1'b0; overflow_r <= 1'b0; underflow_r <= 1'b0;
         dbz_r <= 1'b0;   invalid_r <= 1'b0;
      end else begin
         ready_r <= 1'b0;
         case (state_r)
            IDLE: begin
               if (bus.enable) begin
                  opa_r   <= bus.opa;
                  opb_r   <= bus.opb;
                  rmode_r <= bus.rmode;
                  busy_r  <= 1'b1;
               end
            end
            UNPACK: begin
               sign_r <= opa_r[63] ^ opb_r[63];
               exp_r  <= $signed({2'b00, opa_r[62:52]}) - $signed({2'b00, opb_r[62:52]}) + 13'sd1023;
               mb_r   <= mb_s;
               rem_r  <= {1'b0, ma_s};
               q_r    <= {QBITS{1'b0}};
               cnt_r  <= {CNT_W{1'b0}};
               spc_r  <= spc_s;
            end
            DIVIDE: begin
               q_r   <= {q_r[QBITS-2:0], ge_s};
               rem_r <= rem_nx_s;
               cnt_r <= cnt_r + {{(CNT_W-1){1'b0}}, 1'b1};
            end
            ROUND: begin
               outfp_r     <= res_s;
               inexact_r   <= inexact_s;
               overflow_r  <= overflow_s;
               underflow_r <= underflow_s;
               dbz_r       <= dbz_s;
               invalid_r   <= invalid_s;
               ready_r     <= 1'b1;
               busy_r      <= 1'b0;
            end
            default: ready_r <= 1'b0;
         endcase
      end
   end

   assign bus.busy        = busy_r;
   assign bus.ready       = ready_r;
   assign bus.outfp       = outfp_r;
   assign bus.inexact     = inexact_r;
   assign bus.overflow    = overflow_r;
   assign bus.underflow   = underflow_r;
   assign bus.div_by_zero = dbz_r;
   assign bus.invalid     = invalid_r;

endmodule

// File: tb/tb_fpu_div.sv
// Scoreboard bench for fpu_div: datasheet cases plus randomized operands checked
// against a wide-integer reference divider; a monitor pops expectations on ready.
module tb_fpu_div;
   typedef struct packed {
      logic [63:0] out;
      logic [4:0]  flg;   // {inexact, overflow, underflow, div_by_zero, invalid}
      int          due;
   } exp_t;

   logic clk = 1'b0;
   logic rst;
   logic srst;
   int   cyc = 0;
   int   checks = 0;
   int   errors = 0;
   int   ready_cnt = 0;
   exp_t exp_q[$];

   fpu_div_if bus();
   fpu_div dut (.clk(clk), .rst(rst), .srst(srst), .bus(bus));

   always #5 clk = ~clk;
   always @(posedge clk) cyc <= cyc + 1;

   task automatic chk(input string name, input logic [63:0] act, input logic [63:0] req);
      checks++;
      if (act !== req) begin
         errors++;
         $display("FAIL %s: got %h, expected %h", name, act, req);
      end
   endtask

   function automatic exp_t mk(input logic [63:0] o, input logic [4:0] f);
      exp_t r;
      r.out = o;
      r.flg = f;
      r.due = 0;
      return r;
   endfunction

   // Reference: exact quotient from 128-bit integer division, then the rounding rules.
   function automatic exp_t model(input logic [63:0] a, input logic [63:0] b, input logic [1:0] rm);
      exp_t r;
      logic s, za, zb, ia, ib, na, nb, g, st, inc;
      logic [127:0] num, den, quo;
      logic [53:0] m;
      int e, sh;
      r  = '0;
      s  = a[63] ^ b[63];
      za = (a[62:52] == 11'd0);
      zb = (b[62:52] == 11'd0);
      ia = (a[62:52] == 11'h7FF) && (a[51:0] == 52'd0);
      ib = (b[62:52] == 11'h7FF) && (b[51:0] == 52'd0);
      na = (a[62:52] == 11'h7FF) && (a[51:0] != 52'd0);
      nb = (b[62:52] == 11'h7FF) && (b[51:0] != 52'd0);
      if (na || nb || (za && zb) || (ia && ib)) begin
         r.out = 64'h7FF8000000000000;
         r.flg = 5'b00001;
      end else if (ia) begin
         r.out = {s, 11'h7FF, 52'd0};
      end else if (zb) begin
         r.out = {s, 11'h7FF, 52'd0};
         r.flg = 5'b00010;
      end else if (za || ib) begin
         r.out = {s, 63'd0};
      end else begin
         num = {75'd0, 1'b1, a[51:0]} << 64;
         den = {75'd0, 1'b1, b[51:0]};
         quo = num / den;
         e = int'(a[62:52]) - int'(b[62:52]) + 1023;
         if (quo[64]) sh = 12;
         else begin
            sh = 11;
            e  = e - 1;
         end
         m  = 54'(quo >> sh);
         g  = quo[sh - 1];
         st = ((quo & ((128'd1 << (sh - 1)) - 128'd1)) != 128'd0) || ((num % den) != 128'd0);
         case (rm)
            2'd0:    inc = g & (st | m[0]);
            2'd1:    inc = 1'b0;
            2'd2:    inc = ~s & (g | st);
            default: inc = s & (g | st);
         endcase
         m = m + 54'(inc);
         if (m[53]) begin
            m = m >> 1;
            e = e + 1;
         end
         if (e >= 2047) begin
            r.flg = 5'b11000;
            if (rm == 2'd1 || (rm == 2'd2 && s) || (rm == 2'd3 && !s)) r.out = {s, 63'h7FEFFFFFFFFFFFFF};
            else r.out = {s, 11'h7FF, 52'd0};
         end else if (e <= 0) begin
            r.out = {s, 63'd0};
            r.flg = 5'b10100;
         end else begin
            r.out = {s, 11'(e), m[51:0]};
            r.flg = {g | st, 4'b0000};
         end
      end
      return r;
   endfunction

   function automatic logic [63:0] rnd_op();
      logic [63:0] v;
      v = {$urandom, $urandom};
      case ($urandom_range(0, 11))
         0: begin
            v[62:52] = 11'd0;
            if ($urandom_range(0, 1) == 0) v[51:0] = 52'd0;
         end
         1: begin
            v[62:52] = 11'h7FF;
            if ($urandom_range(0, 1) == 0) v[51:0] = 52'd0;
         end
         2: v[62:52] = 11'(2046 - $urandom_range(0, 24));
         3: v[62:52] = 11'($urandom_range(1, 24));
         4: begin
            v[62:52] = 11'($urandom_range(1000, 1046));
            v[51:0]  = 52'd0;
         end
         default: v[62:52] = 11'($urandom_range(900, 1150));
      endcase
      return v;
   endfunction

   task automatic issue(input logic [63:0] a, input logic [63:0] b, input logic [1:0] rm, input exp_t e);
      exp_t x;
      int n;
      n = 0;
      while (bus.busy === 1'b1 && n < 200) begin
         @(negedge clk);
         n++;
      end
      if (bus.busy === 1'b1) begin
         checks++;
         errors++;
         $display("FAIL issue_timeout: busy=%b, expected 0", bus.busy);
      end
      x = e;
      x.due = cyc + 58;
      bus.opa    = a;
      bus.opb    = b;
      bus.rmode  = rm;
      bus.enable = 1'b1;
      exp_q.push_back(x);
      @(negedge clk);
      bus.enable = 1'b0;
   endtask

   task automatic wait_idle();
      int n;
      n = 0;
      while ((exp_q.size() != 0 || bus.busy === 1'b1) && n < 300) begin
         @(negedge clk);
         n++;
      end
      checks++;
      if (exp_q.size() != 0 || bus.busy === 1'b1) begin
         errors++;
         $display("FAIL drain_timeout: %0d ops pending, expected 0", exp_q.size());
      end
   endtask

   // Monitor: every ready pulse consumes the oldest expectation
   initial begin
      exp_t e;
      forever begin
         @(negedge clk);
         if (rst === 1'b1 && bus.ready === 1'b1) begin
            ready_cnt++;
            if (exp_q.size() == 0) begin
               checks++;
               errors++;
               $display("FAIL spurious_ready: ready at cycle %0d, expected no pending op", cyc);
            end else begin
               e = exp_q.pop_front();
               chk("outfp", bus.outfp, e.out);
               chk("flags", {59'd0, bus.inexact, bus.overflow, bus.underflow, bus.div_by_zero, bus.invalid},
                   {59'd0, e.flg});
               chk("latency", 64'(cyc), 64'(e.due));
            end
         end
      end
   end

   initial begin
      #500000;
      $display("FAIL watchdog: simulation did not finish, expected completion");
      $fatal(1, "watchdog");
   end

   initial begin
      logic [63:0] a, b;
      logic [1:0]  rm;
      int rc;
      rst = 1'b0;
      srst = 1'b0;
      bus.enable = 1'b0;
      bus.opa = 64'd0;
      bus.opb = 64'd0;
      bus.rmode = 2'd0;
      repeat (3) @(negedge clk);
      chk("reset_outfp", bus.outfp, 64'd0);
      chk("reset_ctl", {57'd0, bus.busy, bus.ready, bus.inexact, bus.overflow, bus.underflow,
                        bus.div_by_zero, bus.invalid}, 64'd0);
      rst = 1'b1;
      @(negedge clk);

      issue(64'h3FF0000000000000, 64'h4008000000000000, 2'b00, mk(64'h3FD5555555555555, 5'b10000));
      issue(64'h3FF0000000000000, 64'h4008000000000000, 2'b10, mk(64'h3FD5555555555556, 5'b10000));
      issue(64'h3FF0000000000000, 64'h4008000000000000, 2'b01, mk(64'h3FD5555555555555, 5'b10000));
      issue(64'h3FF0000000000000, 64'hC008000000000000, 2'b11, mk(64'hBFD5555555555556, 5'b10000));
      issue(64'h3FF0000000000000, 64'hC008000000000000, 2'b10, mk(64'hBFD5555555555555, 5'b10000));
      issue(64'h4018000000000000, 64'hC000000000000000, 2'b00, mk(64'hC008000000000000, 5'b00000));
      issue(64'h3FF0000000000000, 64'h0000000000000000, 2'b00, mk(64'h7FF0000000000000, 5'b00010));
      issue(64'h0000000000000000, 64'h0000000000000000, 2'b00, mk(64'h7FF8000000000000, 5'b00001));
      issue(64'h7FEFFFFFFFFFFFFF, 64'h3FE0000000000000, 2'b00, mk(64'h7FF0000000000000, 5'b11000));
      issue(64'h7FEFFFFFFFFFFFFF, 64'h3FE0000000000000, 2'b01, mk(64'h7FEFFFFFFFFFFFFF, 5'b11000));
      issue(64'h0010000000000000, 64'h4000000000000000, 2'b00, mk(64'h0000000000000000, 5'b10100));
      issue(64'hFFF0000000000000, 64'h3FF0000000000000, 2'b00, mk(64'hFFF0000000000000, 5'b00000));
      issue(64'h3FF0000000000000, 64'h7FF0000000000000, 2'b00, mk(64'h0000000000000000, 5'b00000));
      wait_idle();

      // enable while busy must be ignored
      issue(64'h3FF0000000000000, 64'h4008000000000000, 2'b00, mk(64'h3FD5555555555555, 5'b10000));
      repeat (9) @(negedge clk);
      bus.opa = 64'h4018000000000000;
      bus.opb = 64'hC000000000000000;
      bus.enable = 1'b1;
      @(negedge clk);
      bus.enable = 1'b0;
      wait_idle();

      // reset mid-operation aborts without a ready pulse
      issue(64'h4018000000000000, 64'hC000000000000000, 2'b00, mk(64'hC008000000000000, 5'b00000));
      repeat (19) @(negedge clk);
      rst = 1'b0;
      #1;
      chk("abort_outfp", bus.outfp, 64'd0);
      chk("abort_ctl", {57'd0, bus.busy, bus.ready, bus.inexact, bus.overflow, bus.underflow,
                        bus.div_by_zero, bus.invalid}, 64'd0);
      exp_q.delete();
      rc = ready_cnt;
      repeat (2) @(negedge clk);
      rst = 1'b1;
      repeat (70) @(negedge clk);
      chk("abort_no_ready", 64'(ready_cnt), 64'(rc));
      issue(64'h3FF0000000000000, 64'h4008000000000000, 2'b10, mk(64'h3FD5555555555556, 5'b10000));
      wait_idle();

      // randomized back-to-back operations
      for (int i = 0; i < 60; i++) begin
         a  = rnd_op();
         b  = rnd_op();
         rm = 2'($urandom_range(0, 3));
         issue(a, b, rm, model(a, b, rm));
      end
      wait_idle();

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end
endmodule
